// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: groups the decode-side inputs, the EX/MEM and MEM/WB
// forward sources, and the ALU/EX-side outputs of alu_operand_stage.
//   master : decode/pipeline side (drives id_*, flush, forward sources)
//   slave  : alu_operand_stage (drives op1/op2, ex_*, stall)
interface alu_operand_stage_if #(parameter int XLEN = 32);
  logic            id_valid;
  logic [4:0]      id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [2:0]      id_func3;
  logic            id_instr30;
  logic [1:0]      id_alu_op;
  logic            id_src_a, id_src_b, id_is_load, id_reg_write;
  logic            flush;
  logic [4:0]      exmem_rd;
  logic            exmem_reg_write, exmem_is_load;
  logic [XLEN-1:0] exmem_result;
  logic [4:0]      memwb_rd;
  logic            memwb_reg_write;
  logic [XLEN-1:0] memwb_result;
  logic [XLEN-1:0] op1, op2, ex_store_data;
  logic [2:0]      func3;
  logic            instr30;
  logic [1:0]      alu_op;
  logic            ex_valid, ex_reg_write, ex_is_load;
  logic [4:0]      ex_rd;
  logic            stall;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data,
           id_rs2_data, id_imm, id_pc, id_func3, id_instr30, id_alu_op,
           id_src_a, id_src_b, id_is_load, id_reg_write, flush,
           exmem_rd, exmem_reg_write, exmem_is_load, exmem_result,
           memwb_rd, memwb_reg_write, memwb_result,
    input  op1, op2, ex_store_data, func3, instr30, alu_op,
           ex_valid, ex_reg_write, ex_is_load, ex_rd, stall
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data,
           id_rs2_data, id_imm, id_pc, id_func3, id_instr30, id_alu_op,
           id_src_a, id_src_b, id_is_load, id_reg_write, flush,
           exmem_rd, exmem_reg_write, exmem_is_load, exmem_result,
           memwb_rd, memwb_reg_write, memwb_result,
    output op1, op2, ex_store_data, func3, instr30, alu_op,
           ex_valid, ex_reg_write, ex_is_load, ex_rd, stall
  );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX pipeline register plus operand forwarding for the
// execute stage. Detects load-use hazards (one-cycle stall + bubble) and
// kills the incoming instruction on flush.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (loads a bubble)
//   bus  alu_operand_stage_if.slave: id_* capture inputs, flush, EX/MEM and
//        MEM/WB forward sources; op1/op2/ex_store_data (combinational),
//        func3/instr30/alu_op/ex_* (registered), stall (combinational)
module alu_operand_stage #(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst,
  alu_operand_stage_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [2:0]      func3;
    logic            instr30;
    logic [1:0]      alu_op;
    logic            src_a;
    logic            src_b;
    logic            is_load;
    logic            reg_write;
  } ex_t;

  ex_t             ex_q, ex_d;
  logic            hz;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // EX/MEM wins over MEM/WB; a load in EX/MEM has no data yet, so it never
  // forwards from there. x0 never forwards.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_data,
    input logic [4:0]      em_rd,
    input logic            em_rw,
    input logic            em_ld,
    input logic [XLEN-1:0] em_res,
    input logic [4:0]      mw_rd,
    input logic            mw_rw,
    input logic [XLEN-1:0] mw_res
  );
    if (em_rw && em_rd != 5'd0 && em_rd == addr && !em_ld) return em_res;
    if (mw_rw && mw_rd != 5'd0 && mw_rd == addr)           return mw_res;
    return rf_data;
  endfunction

  always_comb begin
    hz = ex_q.valid && ex_q.is_load && ex_q.rd != 5'd0 && bus.id_valid &&
         (bus.id_rs1_addr == ex_q.rd || bus.id_rs2_addr == ex_q.rd);
    bus.stall = hz && !bus.flush;

    // Flush, stall and an empty decode slot all load an all-zero bubble.
    ex_d = '0;
    if (!bus.flush && !hz && bus.id_valid) begin
      ex_d.valid     = 1'b1;
      ex_d.rs1_addr  = bus.id_rs1_addr;
      ex_d.rs2_addr  = bus.id_rs2_addr;
      ex_d.rd        = bus.id_rd_addr;
      ex_d.rs1_data  = bus.id_rs1_data;
      ex_d.rs2_data  = bus.id_rs2_data;
      ex_d.imm       = bus.id_imm;
      ex_d.pc        = bus.id_pc;
      ex_d.func3     = bus.id_func3;
      ex_d.instr30   = bus.id_instr30;
      ex_d.alu_op    = bus.id_alu_op;
      ex_d.src_a     = bus.id_src_a;
      ex_d.src_b     = bus.id_src_b;
      ex_d.is_load   = bus.id_is_load;
      ex_d.reg_write = bus.id_reg_write;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  always_comb begin
    fwd_rs1 = fwd_sel(ex_q.rs1_addr, ex_q.rs1_data,
                      bus.exmem_rd, bus.exmem_reg_write, bus.exmem_is_load, bus.exmem_result,
                      bus.memwb_rd, bus.memwb_reg_write, bus.memwb_result);
    fwd_rs2 = fwd_sel(ex_q.rs2_addr, ex_q.rs2_data,
                      bus.exmem_rd, bus.exmem_reg_write, bus.exmem_is_load, bus.exmem_result,
                      bus.memwb_rd, bus.memwb_reg_write, bus.memwb_result);
  end

  assign bus.op1           = ex_q.src_a ? ex_q.pc  : fwd_rs1;
  assign bus.op2           = ex_q.src_b ? ex_q.imm : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.func3         = ex_q.func3;
  assign bus.instr30       = ex_q.instr30;
  assign bus.alu_op        = ex_q.alu_op;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_is_load    = ex_q.is_load;
  assign bus.ex_rd         = ex_q.rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_operand_stage_if #(.XLEN(XLEN)) bus ();
  alu_operand_stage #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit valid; bit [4:0] rs1, rs2, rd; bit [31:0] d1, d2, imm, pc;
    bit [2:0] func3; bit i30; bit [1:0] alu_op; bit src_a, src_b, is_load, reg_write;
  } id_t;

  typedef struct {
    bit [4:0] em_rd; bit em_rw, em_ld; bit [31:0] em_res;
    bit [4:0] mw_rd; bit mw_rw; bit [31:0] mw_res;
  } fwd_t;

  typedef struct {
    bit [31:0] op1, op2, sd; bit [2:0] func3; bit i30; bit [1:0] alu_op;
    bit valid, rw, ld; bit [4:0] rd; bit stall;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  id_t  ex_m;        // instruction the reference model believes sits in EX
  fwd_t nofwd;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  // Value an EX-stage register read sees after forwarding.
  function automatic bit [31:0] fwd_val(bit [4:0] a, bit [31:0] rf, fwd_t f);
    if (a == 0) return rf;
    if (f.em_rw && f.em_rd == a && !f.em_ld) return f.em_res;
    if (f.mw_rw && f.mw_rd == a) return f.mw_res;
    return rf;
  endfunction

  function automatic id_t mk(bit [4:0] rs1, bit [4:0] rs2, bit [4:0] rd,
                             bit [31:0] d1, bit [31:0] d2, bit [1:0] op, bit [2:0] f3);
    id_t r = '{default: 0};
    r.valid = 1; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.d1 = d1; r.d2 = d2;
    r.alu_op = op; r.func3 = f3; r.reg_write = 1;
    return r;
  endfunction

  task automatic drive(input id_t id, input fwd_t f, input bit fl);
    bus.id_valid = id.valid;   bus.id_rs1_addr = id.rs1; bus.id_rs2_addr = id.rs2;
    bus.id_rd_addr = id.rd;    bus.id_rs1_data = id.d1;  bus.id_rs2_data = id.d2;
    bus.id_imm = id.imm;       bus.id_pc = id.pc;        bus.id_func3 = id.func3;
    bus.id_instr30 = id.i30;   bus.id_alu_op = id.alu_op;
    bus.id_src_a = id.src_a;   bus.id_src_b = id.src_b;
    bus.id_is_load = id.is_load; bus.id_reg_write = id.reg_write;
    bus.flush = fl;
    bus.exmem_rd = f.em_rd; bus.exmem_reg_write = f.em_rw; bus.exmem_is_load = f.em_ld;
    bus.exmem_result = f.em_res;
    bus.memwb_rd = f.mw_rd; bus.memwb_reg_write = f.mw_rw; bus.memwb_result = f.mw_res;
  endtask

  function automatic bit model_stall(id_t id, bit fl);
    return ex_m.valid && ex_m.is_load && ex_m.rd != 0 && id.valid &&
           (id.rs1 == ex_m.rd || id.rs2 == ex_m.rd) && !fl;
  endfunction

  // One cycle: drive inputs just after a rising edge, queue the expected
  // outputs for the current EX occupant, then advance the model at the edge.
  task automatic cyc(input id_t id, input fwd_t f, input bit fl);
    exp_t e;
    bit   st, hzd;
    bit [31:0] r1, r2;
    drive(id, f, fl);
    r1 = fwd_val(ex_m.rs1, ex_m.d1, f);
    r2 = fwd_val(ex_m.rs2, ex_m.d2, f);
    st = model_stall(id, fl);
    hzd = model_stall(id, 1'b0);
    e.op1 = ex_m.src_a ? ex_m.pc : r1;
    e.op2 = ex_m.src_b ? ex_m.imm : r2;
    e.sd = r2; e.func3 = ex_m.func3; e.i30 = ex_m.i30; e.alu_op = ex_m.alu_op;
    e.valid = ex_m.valid; e.rw = ex_m.reg_write; e.ld = ex_m.is_load; e.rd = ex_m.rd;
    e.stall = st;
    q.push_back(e);
    @(posedge clk);
    if (fl || hzd || !id.valid) ex_m = '{default: 0};
    else ex_m = id;
    #1;
  endtask

  // Monitor: compares the DUT against every queued expectation mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("op1", bus.op1, e.op1);
      chk("op2", bus.op2, e.op2);
      chk("store_data", bus.ex_store_data, e.sd);
      chk("func3", 32'(bus.func3), 32'(e.func3));
      chk("instr30", 32'(bus.instr30), 32'(e.i30));
      chk("alu_op", 32'(bus.alu_op), 32'(e.alu_op));
      chk("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
      chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(e.rw));
      chk("ex_is_load", 32'(bus.ex_is_load), 32'(e.ld));
      chk("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
      chk("stall", 32'(bus.stall), 32'(e.stall));
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_op1"}, bus.op1, 0);
    chk({tag, "_op2"}, bus.op2, 0);
    chk({tag, "_sd"}, bus.ex_store_data, 0);
    chk({tag, "_ctl"}, {bus.func3, bus.instr30, bus.alu_op, bus.ex_valid,
                        bus.ex_reg_write, bus.ex_is_load, bus.ex_rd}, 0);
    chk({tag, "_stall"}, 32'(bus.stall), 0);
  endtask

  function automatic id_t rnd_id();
    id_t r;
    r.valid = ($urandom_range(0, 3) != 0);
    r.rs1 = 5'($urandom_range(0, 7)); r.rs2 = 5'($urandom_range(0, 7));
    r.rd = 5'($urandom_range(0, 7));
    r.d1 = $urandom; r.d2 = $urandom; r.imm = $urandom; r.pc = $urandom;
    r.func3 = 3'($urandom_range(0, 7)); r.i30 = 1'($urandom_range(0, 1));
    r.alu_op = 2'($urandom_range(0, 3));
    r.src_a = 1'($urandom_range(0, 1)); r.src_b = 1'($urandom_range(0, 1));
    r.is_load = ($urandom_range(0, 2) == 0); r.reg_write = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic fwd_t rnd_fwd();
    fwd_t f;
    f.em_rd = 5'($urandom_range(0, 7)); f.em_rw = 1'($urandom_range(0, 1));
    f.em_ld = ($urandom_range(0, 3) == 0); f.em_res = $urandom;
    f.mw_rd = 5'($urandom_range(0, 7)); f.mw_rw = 1'($urandom_range(0, 1));
    f.mw_res = $urandom;
    return f;
  endfunction

  task automatic rnd_run(input int n);
    for (int i = 0; i < n; i++) cyc(rnd_id(), rnd_fwd(), $urandom_range(0, 9) == 0);
  endtask

  initial begin
    id_t  id;
    fwd_t f;
    nofwd = '{default: 0};
    ex_m  = '{default: 0};
    // Drive a live-looking decode and forward sources during reset.
    id = mk(5'd1, 5'd2, 5'd3, 32'd4, 32'd2, 2'd1, 3'd0);
    f = '{em_rd: 5'd1, em_rw: 1, em_ld: 0, em_res: 32'hdead, mw_rd: 5'd2, mw_rw: 1, mw_res: 32'hbeef};
    drive(id, f, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1'b0;

    // ADD x3 = x1 + x2 (4 + 2)
    cyc(id, nofwd, 0);
    // x5-based instruction enters EX; ADD results visible now
    id = mk(5'd5, 5'd0, 5'd6, 32'd7, 32'd0, 2'd0, 3'd0);
    cyc(id, nofwd, 0);
    // EX/MEM and MEM/WB both write x5: EX/MEM wins (op1=20)
    f = '{em_rd: 5'd5, em_rw: 1, em_ld: 0, em_res: 32'd20, mw_rd: 5'd5, mw_rw: 1, mw_res: 32'd99};
    cyc(id, f, 0);
    // exmem_rd=0: MEM/WB supplies 99; next decode reads rs2=x0
    id = mk(5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 2'd0, 3'd0);
    f.em_rd = 5'd0;
    cyc(id, f, 0);
    // x0 guard: exmem writes "x0" with -15, op2 must stay 0; LW x7 decoded
    id = mk(5'd1, 5'd0, 5'd7, 32'd16, 32'd0, 2'd0, 3'd2);
    id.is_load = 1; id.src_b = 1; id.imm = 32'd4;
    f = '{em_rd: 5'd0, em_rw: 1, em_ld: 0, em_res: -32'sd15, mw_rd: 5'd0, mw_rw: 0, mw_res: 0};
    cyc(id, f, 0);
    // SUB x9 = x1 - x7 with LW x7 in EX: stall, then captured after bubble
    id = mk(5'd1, 5'd7, 5'd9, 32'd50, 32'd0, 2'd2, 3'd0);
    id.i30 = 1;
    cyc(id, nofwd, 0);
    cyc(id, nofwd, 0);
    // SUB in EX, load data arrives via MEM/WB; flush kills the decode slot
    f = '{em_rd: 5'd0, em_rw: 0, em_ld: 0, em_res: 0, mw_rd: 5'd7, mw_rw: 1, mw_res: -32'sd256};
    cyc(mk(5'd3, 5'd4, 5'd10, 32'd1, 32'd2, 2'd1, 3'd1), f, 1);
    // LW x9 enters; then a dependent op arrives with flush: stall must stay 0
    id = mk(5'd2, 5'd0, 5'd9, 32'd8, 32'd0, 2'd0, 3'd2);
    id.is_load = 1;
    cyc(id, nofwd, 0);
    cyc(mk(5'd9, 5'd1, 5'd11, 32'd0, 32'd1, 2'd0, 3'd0), nofwd, 1);
    // PC/imm select, store data still follows forwarded rs2
    id = mk(5'd0, 5'd4, 5'd12, 32'd0, 32'd33, 2'd0, 3'd2);
    id.src_a = 1; id.pc = 32'h100; id.src_b = 1; id.imm = -32'sd3;
    cyc(id, nofwd, 0);
    f = '{em_rd: 5'd4, em_rw: 1, em_ld: 0, em_res: 32'h55, mw_rd: 5'd0, mw_rw: 0, mw_res: 0};
    cyc('{default: 0}, f, 0);

    rnd_run(400);

    // Async reset while a load-use stall is pending
    id = mk(5'd1, 5'd0, 5'd7, 32'd0, 32'd0, 2'd0, 3'd2);
    id.is_load = 1;
    cyc(id, nofwd, 0);
    id = mk(5'd7, 5'd7, 5'd3, 32'd1, 32'd2, 2'd0, 3'd0);
    drive(id, nofwd, 0);
    #1 chk("pre_reset_stall", 32'(bus.stall), 32'(model_stall(id, 0)));
    rst = 1'b1;
    #1 chk_zero("mid_reset");
    rst = 1'b0;
    ex_m = '{default: 0};
    #1 chk("post_reset_stall", 32'(bus.stall), 0);

    rnd_run(400);

    @(negedge clk);
    #1 chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

ID/EX pipeline register and operand-forwarding front end for the RISC-V core's execute stage. Captures decoded instruction fields each cycle, resolves rs1/rs2 data hazards by forwarding from the EX/MEM and MEM/WB stages, and drives the `alu` block's `op1`, `op2`, `func3`, `instr30` and `alu_op` inputs directly. It also detects load-use hazards, stalls decode for one cycle and inserts a bubble. Branch flushes are handled here too.

## Interface
- XLEN, 32, datapath width
- Clock/reset: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  register indices
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
- id_imm, id_pc  in  XLEN each  immediate and PC
- id_func3  in  3  instruction func3
- id_instr30  in  1  instruction bit 30
- id_alu_op  in  2  ALU operation class
- id_src_a  in  1  0=rs1, 1=pc
- id_src_b  in  1  0=rs2, 1=imm
- id_is_load, id_reg_write  in  1 each  control flags
- flush  in  1  taken branch/jump; kill the instruction entering EX
- exmem_rd  in  5; exmem_reg_write, exmem_is_load  in  1; exmem_result  in  XLEN  (EX/MEM forward source)
- memwb_rd  in  5; memwb_reg_write  in  1; memwb_result  in  XLEN  (MEM/WB forward source)
- op1, op2  out  XLEN  ALU operands (combinational from registers and forward sources)
- func3  out  3; instr30  out  1; alu_op  out  2  registered, to ALU
- ex_valid, ex_reg_write, ex_is_load  out  1 each  registered
- ex_rd  out  5  registered
- ex_store_data  out  XLEN  forwarded rs2 for stores
- stall  out  1  combinational; holds PC and IF/ID when high

## Operation
- Registered state: valid, rs1/rs2 addr, rd, rs1/rs2 data, imm, pc, func3, instr30, alu_op, src_a, src_b, is_load, reg_write.
- Bubble: valid=0, reg_write=0, is_load=0, rd=0, func3=0, instr30=0, alu_op=0. Data fields are don't-care but are zeroed.
- Reset: all registered fields take the bubble value. All outputs are 0 and stall=0 during reset.
- Hazard detection: `hz = ex_valid & ex_is_load & ex_rd!=0 & id_valid & (id_rs1_addr==ex_rd | id_rs2_addr==ex_rd)`. `stall = hz & ~flush`.
- Update priority at each edge: flush, then stall (both load a bubble), then normal capture of id_* (id_valid=0 captures a bubble).
- Forwarding, applied to each of rs1 and rs2 on the registered address:
  - EX/MEM hit: exmem_reg_write & exmem_rd!=0 & exmem_rd==addr & ~exmem_is_load selects exmem_result.
  - Otherwise MEM/WB hit: memwb_reg_write & memwb_rd!=0 & memwb_rd==addr selects memwb_result.
  - Otherwise the registered register-file data is used.
- EX/MEM takes precedence over MEM/WB. Register x0 never forwards.
- Operand select:
  - op1 = src_a ? pc : fwd_rs1.
  - op2 = src_b ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2 in all cases.
- Decode and register-file write-through are outside this block; the register file must provide same-cycle write bypass.

## Timing
- Latency: id_* fields appear on func3/instr30/alu_op/ex_* one cycle after the capturing edge.
- op1/op2 are combinational from the registers and the forward inputs, so there is no extra cycle.
- Load-use: stall is high for exactly one cycle. After the bubble edge, ex_is_load=0, so hz drops and the held decode instruction is captured on the next edge.
- Forwarding from MEM/WB then supplies the load data.
- Simultaneous flush and hazard: stall=0 and a bubble is loaded. Decode is expected to be flushed upstream by the same flush.
- Asynchronous reset mid-stall: outputs clear immediately, stall=0 on the next evaluation, and there is no pending state.

## Test plan
- Reset then capture: assert rst, check all outputs 0. Release rst and drive ADD with rs1_data=4, rs2_data=2, src_b=0, alu_op=1, func3=0. After 1 edge: op1=4, op2=2, alu_op=1, ex_valid=1.
- EX/MEM forward: EX holds rs1=x5; exmem_rd=5, exmem_reg_write=1, exmem_result=20; memwb_rd=5, memwb_result=99 → op1=20. With exmem_rd=0 → op1=99.
- x0 guard: rs2=x0, rs2_data=0, exmem_rd=0, exmem_reg_write=1, exmem_result=-15 → op2=0.
- Load-use: EX holds LW x7 (is_load=1, rd=7); decode SUB with rs2=x7 → stall=1 for one cycle and next-edge ex_valid=0. Next edge captures SUB (instr30=1); with memwb_rd=7, memwb_result=-256 → op2=-256.
- Flush: flush=1 with a valid decode instruction → after the edge ex_valid=0, ex_reg_write=0, alu_op=0. Flush together with a load-use hazard → stall=0.
- Immediate/PC select: src_a=1, pc=0x100, src_b=1, imm=-3, func3=2 → op1=0x100, op2=0xFFFFFFFD, func3=2. ex_store_data still equals forwarded rs2.
